// File: rtl/mem_stage_ls.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_ls
//  Purpose  : Memory-access pipeline stage between EX and WB. Waits for the
//             data-SRAM response of a load/store issued in EX, aligns and
//             extends load data, drops responses of flushed instructions and
//             exports a forwarding bundle with a load-pending flag.
//  Ports    : clk, resetn (async, active-low)
//             ex_to_mem_valid / ex_to_mem_wire / mem_allowin   : EX handshake
//             mem_to_wb_valid / mem_to_wb_wire / wb_allowin    : WB handshake
//             data_sram_data_ok / data_sram_rdata              : bus response
//             mem_flush                                        : cancel
//             mem_rf_zip                                       : forwarding
//  Options  : MEM_RESP_BUF_EN - adds a response buffer so a response that
//             arrives while WB is stalled is held until transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ls #(
    parameter int DW      = 32,
    parameter int RA_W    = 5,
    parameter int MAX_OUT = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    ex_to_mem_valid,
    input  logic [RA_W+2*DW+5:0]    ex_to_mem_wire,
    output logic                    mem_allowin,
    input  logic                    wb_allowin,
    output logic                    mem_to_wb_valid,
    output logic [RA_W+2*DW:0]      mem_to_wb_wire,
    input  logic                    data_sram_data_ok,
    input  logic [DW-1:0]           data_sram_rdata,
    input  logic                    mem_flush,
    output logic [RA_W+DW+1:0]      mem_rf_zip
);

    localparam int c_PL_W  = RA_W + 2*DW + 6;
    localparam int c_OFF_W = (DW == 64) ? 3 : 2;
    localparam int c_CNT_W = $clog2(MAX_OUT + 1);
    localparam int c_SUM_W = c_CNT_W + 2;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_OUT);
    localparam logic [c_SUM_W-1:0] c_SUM_MAX = c_SUM_W'(MAX_OUT);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                 r_mem_valid;
    logic [c_PL_W-1:0]    r_payload;
    logic                 r_resp_got;
    logic [c_CNT_W-1:0]   r_discard_cnt;

    // Payload fields {rf_we, rf_waddr, pc, alu_result, res_from_mem, ld_op, req_issued}
    logic                 w_rf_we;
    logic [RA_W-1:0]      w_rf_waddr;
    logic [DW-1:0]        w_pc;
    logic [DW-1:0]        w_alu_result;
    logic                 w_res_from_mem;
    logic [2:0]           w_ld_op;
    logic                 w_req_issued;
    logic                 w_ex_req_issued;

    assign w_rf_we         = r_payload[c_PL_W-1];
    assign w_rf_waddr      = r_payload[5+2*DW+RA_W-1 : 5+2*DW];
    assign w_pc            = r_payload[5+2*DW-1 : 5+DW];
    assign w_alu_result    = r_payload[5+DW-1 : 5];
    assign w_res_from_mem  = r_payload[4];
    assign w_ld_op         = r_payload[3:1];
    assign w_req_issued    = r_payload[0];
    assign w_ex_req_issued = ex_to_mem_wire[0];

    // ------------------------------------------------------------------------
    // Response classification and handshake
    // ------------------------------------------------------------------------
    logic w_own;        // response belongs to the current instruction
    logic w_drop;       // response belongs to a flushed instruction
    logic w_waiting;    // current instruction still needs its response
    logic w_own_take;   // current instruction consumes a response now
    logic w_ready_go;
    logic w_capture;

    assign w_own      = data_sram_data_ok & (r_discard_cnt == '0);
    assign w_drop     = data_sram_data_ok & (r_discard_cnt != '0);
    assign w_waiting  = r_mem_valid & w_req_issued & ~r_resp_got;
    assign w_own_take = w_own & w_waiting;
    assign w_ready_go = ~w_req_issued | r_resp_got | w_own;

    assign mem_allowin     = ~r_mem_valid | (w_ready_go & wb_allowin);
    assign mem_to_wb_valid = r_mem_valid & w_ready_go & ~mem_flush;
    assign w_capture       = ex_to_mem_valid & mem_allowin & ~mem_flush;

    // ------------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_valid <= 1'b0;
            r_payload   <= '0;
            r_resp_got  <= 1'b0;
        end else begin
            if (mem_flush)
                r_mem_valid <= 1'b0;
            else if (mem_allowin)
                r_mem_valid <= ex_to_mem_valid;

            if (w_capture)
                r_payload <= ex_to_mem_wire;

            // resp_got only lives while the same instruction stays in the stage
            if (mem_flush || mem_allowin)
                r_resp_got <= 1'b0;
            else if (w_own_take)
                r_resp_got <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Discard counter: counts responses still owed to flushed instructions
    // ------------------------------------------------------------------------
    logic                 w_inc_mem;
    logic                 w_inc_ex;
    logic [c_SUM_W-1:0]   w_cnt_sum;
    logic                 w_cnt_ovf;
    logic [c_CNT_W-1:0]   w_cnt_next;

    // An own response in the flush cycle has already arrived, so it is not owed
    assign w_inc_mem = mem_flush & w_waiting & ~w_own;
    assign w_inc_ex  = mem_flush & ex_to_mem_valid & w_ex_req_issued;

    always_comb begin
        w_cnt_sum = {2'b00, r_discard_cnt}
                  + {{(c_SUM_W-1){1'b0}}, w_inc_mem}
                  + {{(c_SUM_W-1){1'b0}}, w_inc_ex}
                  - {{(c_SUM_W-1){1'b0}}, w_drop};
        w_cnt_ovf  = (w_cnt_sum > c_SUM_MAX);
        w_cnt_next = w_cnt_ovf ? c_CNT_MAX : w_cnt_sum[c_CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_discard_cnt <= '0;
        else
            r_discard_cnt <= w_cnt_next;
    end

    // ------------------------------------------------------------------------
    // Load data source
    // ------------------------------------------------------------------------
    logic [DW-1:0] w_load_src;

`ifdef MEM_RESP_BUF_EN
    logic [DW-1:0] r_resp_buf;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_resp_buf <= '0;
        else if (w_own_take && !wb_allowin && !mem_flush)
            r_resp_buf <= data_sram_rdata;
    end

    assign w_load_src = r_resp_got ? r_resp_buf : data_sram_rdata;
`else
    assign w_load_src = data_sram_rdata;
`endif

    // ------------------------------------------------------------------------
    // Alignment and extension
    // ------------------------------------------------------------------------
    logic [c_OFF_W-1:0]   w_off;
    logic [c_OFF_W+2:0]   w_shamt;
    logic [DW-1:0]        w_shifted;
    logic [DW-1:0]        w_ext_w;
    logic [DW-1:0]        w_ext_wu;
    logic [DW-1:0]        w_load_data;
    logic [DW-1:0]        w_rf_wdata;

    assign w_off     = w_alu_result[c_OFF_W-1:0];
    assign w_shamt   = {w_off, 3'b000};
    assign w_shifted = w_load_src >> w_shamt;

    generate
        if (DW == 64) begin : g_dw64
            assign w_ext_w  = {{(DW-32){w_shifted[31]}}, w_shifted[31:0]};
            assign w_ext_wu = {{(DW-32){1'b0}},          w_shifted[31:0]};
        end else begin : g_dw32
            assign w_ext_w  = w_shifted;
            assign w_ext_wu = w_shifted;
        end
    endgenerate

    always_comb begin
        w_load_data = w_shifted;
        case (w_ld_op)
            3'b000:  w_load_data = {{(DW-8){w_shifted[7]}},   w_shifted[7:0]};
            3'b001:  w_load_data = {{(DW-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load_data = w_ext_w;
            3'b011:  w_load_data = w_shifted;
            3'b100:  w_load_data = {{(DW-8){1'b0}},  w_shifted[7:0]};
            3'b101:  w_load_data = {{(DW-16){1'b0}}, w_shifted[15:0]};
            3'b110:  w_load_data = w_ext_wu;
            default: w_load_data = w_shifted;
        endcase
    end

    assign w_rf_wdata = w_res_from_mem ? w_load_data : w_alu_result;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    logic w_mem_loading;

    assign w_mem_loading  = r_mem_valid & w_res_from_mem & ~w_ready_go;
    assign mem_to_wb_wire = {w_rf_we, w_rf_waddr, w_rf_wdata, w_pc};
    assign mem_rf_zip     = {w_rf_we & r_mem_valid, w_rf_waddr, w_rf_wdata, w_mem_loading};

    // ------------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
    // More responses owed than the bus can have outstanding
    a_discard_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !w_cnt_ovf);
`ifndef MEM_RESP_BUF_EN
    // Without a buffer the response is lost if WB is not accepting
    a_resp_without_wb: assert property (@(posedge clk) disable iff (!resetn)
        !(w_own_take && !wb_allowin && !mem_flush));
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ls.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_ls
//  Purpose  : Directed self-checking bench for mem_stage_ls (DW=32, RA_W=5,
//             MAX_OUT=2). The response-buffer scenario runs only when
//             MEM_RESP_BUF_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ls;

    localparam int DW   = 32;
    localparam int RA_W = 5;
    localparam int c_PL_W = RA_W + 2*DW + 6;
    localparam int c_WB_W = RA_W + 2*DW + 1;
    localparam int c_ZP_W = RA_W + DW + 2;

    logic                 clk;
    logic                 resetn;
    logic                 ex_to_mem_valid;
    logic [c_PL_W-1:0]    ex_to_mem_wire;
    logic                 mem_allowin;
    logic                 wb_allowin;
    logic                 mem_to_wb_valid;
    logic [c_WB_W-1:0]    mem_to_wb_wire;
    logic                 data_sram_data_ok;
    logic [DW-1:0]        data_sram_rdata;
    logic                 mem_flush;
    logic [c_ZP_W-1:0]    mem_rf_zip;

    int n_checks;
    int n_errors;

    mem_stage_ls #(.DW(DW), .RA_W(RA_W), .MAX_OUT(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ex_to_mem_valid   (ex_to_mem_valid),
        .ex_to_mem_wire    (ex_to_mem_wire),
        .mem_allowin       (mem_allowin),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_to_wb_wire    (mem_to_wb_wire),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mem_flush         (mem_flush),
        .mem_rf_zip        (mem_rf_zip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [c_PL_W-1:0] pl(input logic we, input logic [RA_W-1:0] wa,
                                             input logic [DW-1:0] pc, input logic [DW-1:0] alu,
                                             input logic rfm, input logic [2:0] op,
                                             input logic req);
        return {we, wa, pc, alu, rfm, op, req};
    endfunction

    task automatic next_drive;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_valid: got %b want 0", mem_to_wb_valid);
        end
        n_checks++;
        if (mem_allowin !== 1'b1) begin
            n_errors++; $display("FAIL reset_allowin: got %b want 1", mem_allowin);
        end
        n_checks++;
        if (mem_rf_zip !== '0) begin
            n_errors++; $display("FAIL reset_zip: got %h want 0", mem_rf_zip);
        end
        n_checks++;
        if (mem_to_wb_wire !== '0) begin
            n_errors++; $display("FAIL reset_wire: got %h want 0", mem_to_wb_wire);
        end
        resetn = 1'b1;
    endtask

    task automatic test_alu_op;
        next_drive();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = pl(1'b1, 5'd3, 32'h0000_0100, 32'h0000_1234, 1'b0, 3'b000, 1'b0);
        next_drive();
        ex_to_mem_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_to_wb_valid !== 1'b1) begin
            n_errors++; $display("FAIL alu_valid: got %b want 1", mem_to_wb_valid);
        end
        n_checks++;
        if (mem_to_wb_wire !== {1'b1, 5'd3, 32'h0000_1234, 32'h0000_0100}) begin
            n_errors++; $display("FAIL alu_wire: got %h want %h", mem_to_wb_wire,
                                 {1'b1, 5'd3, 32'h0000_1234, 32'h0000_0100});
        end
        n_checks++;
        if (mem_rf_zip !== {1'b1, 5'd3, 32'h0000_1234, 1'b0}) begin
            n_errors++; $display("FAIL alu_zip: got %h want %h", mem_rf_zip,
                                 {1'b1, 5'd3, 32'h0000_1234, 1'b0});
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            n_errors++; $display("FAIL alu_drain: got %b want 0", mem_to_wb_valid);
        end
    endtask

    task automatic test_lb_signed;
        next_drive();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = pl(1'b1, 5'd5, 32'h0000_0104, 32'h0000_1003, 1'b1, 3'b000, 1'b1);
        next_drive();
        ex_to_mem_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_rf_zip[0] !== 1'b1 || mem_to_wb_valid !== 1'b0) begin
                n_errors++; $display("FAIL lb_wait%0d: got loading=%b valid=%b want loading=1 valid=0",
                                     i, mem_rf_zip[0], mem_to_wb_valid);
            end
            next_drive();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_FF00;
        @(negedge clk);
        n_checks++;
        if (mem_to_wb_valid !== 1'b1) begin
            n_errors++; $display("FAIL lb_valid: got %b want 1", mem_to_wb_valid);
        end
        n_checks++;
        if (mem_to_wb_wire !== {1'b1, 5'd5, 32'hFFFF_FF80, 32'h0000_0104}) begin
            n_errors++; $display("FAIL lb_wire: got %h want %h", mem_to_wb_wire,
                                 {1'b1, 5'd5, 32'hFFFF_FF80, 32'h0000_0104});
        end
        n_checks++;
        if (mem_rf_zip[0] !== 1'b0) begin
            n_errors++; $display("FAIL lb_loading_clear: got %b want 0", mem_rf_zip[0]);
        end
        next_drive();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        @(negedge clk);
        n_checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            n_errors++; $display("FAIL lb_drain: got %b want 0", mem_to_wb_valid);
        end
    endtask

    // Response in the very cycle after capture: zero added latency
    task automatic test_lhu_unsigned;
        next_drive();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = pl(1'b1, 5'd6, 32'h0000_0108, 32'h0000_2002, 1'b1, 3'b101, 1'b1);
        next_drive();
        ex_to_mem_valid   = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h9ABC_0000;
        @(negedge clk);
        n_checks++;
        if (mem_to_wb_valid !== 1'b1) begin
            n_errors++; $display("FAIL lhu_valid: got %b want 1", mem_to_wb_valid);
        end
        n_checks++;
        if (mem_to_wb_wire[2*DW-1:DW] !== 32'h0000_9ABC) begin
            n_errors++; $display("FAIL lhu_wdata: got %h want 00009abc", mem_to_wb_wire[2*DW-1:DW]);
        end
        next_drive();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        @(negedge clk);
    endtask

    task automatic test_flush_discard;
        next_drive();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = pl(1'b1, 5'd7, 32'h0000_0200, 32'h0000_3000, 1'b1, 3'b010, 1'b1);
        next_drive();
        ex_to_mem_wire  = pl(1'b1, 5'd8, 32'h0000_0204, 32'h0000_3004, 1'b1, 3'b010, 1'b1);
        mem_flush       = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_valid: got %b want 0", mem_to_wb_valid);
        end
        next_drive();
        mem_flush      = 1'b0;
        ex_to_mem_wire = pl(1'b1, 5'd9, 32'h0000_0208, 32'h0000_3008, 1'b1, 3'b010, 1'b1);
        @(negedge clk);
        n_checks++;
        if (dut.r_discard_cnt !== 2'd2) begin
            n_errors++; $display("FAIL flush_cnt: got %0d want 2", dut.r_discard_cnt);
        end
        next_drive();
        ex_to_mem_valid   = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        @(negedge clk);
        n_checks++;
        if (mem_to_wb_valid !== 1'b0 || mem_rf_zip[0] !== 1'b1) begin
            n_errors++; $display("FAIL flush_drop1: got valid=%b loading=%b want valid=0 loading=1",
                                 mem_to_wb_valid, mem_rf_zip[0]);
        end
        next_drive();
        data_sram_rdata = 32'h2222_2222;
        @(negedge clk);
        n_checks++;
        if (mem_to_wb_valid !== 1'b0 || dut.r_discard_cnt !== 2'd1) begin
            n_errors++; $display("FAIL flush_drop2: got valid=%b cnt=%0d want valid=0 cnt=1",
                                 mem_to_wb_valid, dut.r_discard_cnt);
        end
        next_drive();
        data_sram_rdata = 32'h3333_3333;
        @(negedge clk);
        n_checks++;
        if (mem_to_wb_valid !== 1'b1) begin
            n_errors++; $display("FAIL flush_own_valid: got %b want 1", mem_to_wb_valid);
        end
        n_checks++;
        if (mem_to_wb_wire !== {1'b1, 5'd9, 32'h3333_3333, 32'h0000_0208}) begin
            n_errors++; $display("FAIL flush_own_wire: got %h want %h", mem_to_wb_wire,
                                 {1'b1, 5'd9, 32'h3333_3333, 32'h0000_0208});
        end
        next_drive();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        @(negedge clk);
        n_checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_drain: got %b want 0", mem_to_wb_valid);
        end
    endtask

    task automatic test_flush_with_data_ok;
        next_drive();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = pl(1'b1, 5'd10, 32'h0000_0300, 32'h0000_4000, 1'b1, 3'b010, 1'b1);
        next_drive();
        ex_to_mem_valid   = 1'b0;
        mem_flush         = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5555_5555;
        @(negedge clk);
        n_checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            n_errors++; $display("FAIL flushok_valid: got %b want 0", mem_to_wb_valid);
        end
        next_drive();
        mem_flush         = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        @(negedge clk);
        n_checks++;
        if (dut.r_discard_cnt !== 2'd0) begin
            n_errors++; $display("FAIL flushok_cnt: got %0d want 0", dut.r_discard_cnt);
        end
        n_checks++;
        if (mem_allowin !== 1'b1 || mem_to_wb_valid !== 1'b0) begin
            n_errors++; $display("FAIL flushok_empty: got allowin=%b valid=%b want 1/0",
                                 mem_allowin, mem_to_wb_valid);
        end
    endtask

    task automatic test_stall;
        next_drive();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = pl(1'b1, 5'd4, 32'h0000_0400, 32'h0000_ABCD, 1'b0, 3'b000, 1'b0);
        wb_allowin      = 1'b0;
        next_drive();
        ex_to_mem_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_to_wb_valid !== 1'b1 || mem_allowin !== 1'b0 ||
                mem_to_wb_wire !== {1'b1, 5'd4, 32'h0000_ABCD, 32'h0000_0400}) begin
                n_errors++; $display("FAIL stall_hold%0d: got valid=%b allowin=%b wire=%h want 1/0/%h",
                                     i, mem_to_wb_valid, mem_allowin, mem_to_wb_wire,
                                     {1'b1, 5'd4, 32'h0000_ABCD, 32'h0000_0400});
            end
            next_drive();
        end
        wb_allowin = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_allowin !== 1'b1 || mem_to_wb_valid !== 1'b1) begin
            n_errors++; $display("FAIL stall_release: got allowin=%b valid=%b want 1/1",
                                 mem_allowin, mem_to_wb_valid);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            n_errors++; $display("FAIL stall_drain: got %b want 0", mem_to_wb_valid);
        end
    endtask

    task automatic test_async_reset;
        // Leave one response owed, then park an ALU op stalled by WB
        next_drive();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = pl(1'b1, 5'd11, 32'h0000_0500, 32'h0000_5000, 1'b1, 3'b010, 1'b1);
        next_drive();
        ex_to_mem_valid = 1'b0;
        mem_flush       = 1'b1;
        next_drive();
        mem_flush       = 1'b0;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = pl(1'b1, 5'd12, 32'h0000_0504, 32'h0000_0077, 1'b0, 3'b000, 1'b0);
        wb_allowin      = 1'b0;
        next_drive();
        ex_to_mem_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_to_wb_valid !== 1'b1 || dut.r_discard_cnt !== 2'd1) begin
            n_errors++; $display("FAIL areset_pre: got valid=%b cnt=%0d want 1/1",
                                 mem_to_wb_valid, dut.r_discard_cnt);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (mem_to_wb_valid !== 1'b0 || mem_allowin !== 1'b1) begin
            n_errors++; $display("FAIL areset_out: got valid=%b allowin=%b want 0/1",
                                 mem_to_wb_valid, mem_allowin);
        end
        n_checks++;
        if (dut.r_discard_cnt !== 2'd0 || mem_rf_zip !== '0) begin
            n_errors++; $display("FAIL areset_state: got cnt=%0d zip=%h want 0/0",
                                 dut.r_discard_cnt, mem_rf_zip);
        end
        wb_allowin = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
    endtask

`ifdef MEM_RESP_BUF_EN
    task automatic test_resp_buffer;
        next_drive();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = pl(1'b1, 5'd13, 32'h0000_0600, 32'h0000_6000, 1'b1, 3'b010, 1'b1);
        next_drive();
        ex_to_mem_valid   = 1'b0;
        wb_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        next_drive();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0BAD_0BAD;
        next_drive();
        next_drive();
        wb_allowin = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_to_wb_valid !== 1'b1 || mem_to_wb_wire[2*DW-1:DW] !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL buf_data: got valid=%b wdata=%h want 1/deadbeef",
                                 mem_to_wb_valid, mem_to_wb_wire[2*DW-1:DW]);
        end
        next_drive();
        data_sram_rdata = '0;
        @(negedge clk);
    endtask
`endif

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        resetn            = 1'b0;
        ex_to_mem_valid   = 1'b0;
        ex_to_mem_wire    = '0;
        wb_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        mem_flush         = 1'b0;

        test_reset();
        test_alu_op();
        test_lb_signed();
        test_lhu_unsigned();
        test_flush_discard();
        test_flush_with_data_ok();
        test_stall();
        test_async_reset();
`ifdef MEM_RESP_BUF_EN
        test_resp_buffer();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_ls.md
# mem_stage_ls

Parametrised memory-access stage for the five-stage pipeline, sitting between EX and WB. The stage:
- waits for the data-SRAM response of a load or store issued in EX;
- aligns and sign- or zero-extends load data;
- drops responses that belong to flushed instructions;
- exports a forwarding bundle with a load-pending flag for ID interlock.

## Interface
Parameters:
- DW, 32, data and address width (32 or 64).
- RA_W, 5, register-file address width.
- MAX_OUT, 2, maximum outstanding data-bus requests; sets the discard-counter range 0..MAX_OUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ex_to_mem_valid  in  1  EX holds a valid instruction.
- ex_to_mem_wire  in  RA_W+2*DW+6  payload {rf_we, rf_waddr, pc, alu_result, res_from_mem, ld_op[2:0], req_issued}.
  - ld_op: 000=B, 001=H, 010=W, 100=BU, 101=HU; 011 is D when DW=64.
  - req_issued: EX had a bus request accepted for this instruction.
- mem_allowin  out  1  stage can accept a payload this cycle.
- wb_allowin  in  1  WB can accept.
- mem_to_wb_valid  out  1  result valid toward WB.
- mem_to_wb_wire  out  1+RA_W+2*DW  {rf_we, rf_waddr, rf_wdata, pc}.
- data_sram_data_ok  in  1  one read or write response this cycle; responses arrive in order.
- data_sram_rdata  in  DW  response data, qualified by data_ok.
- mem_flush  in  1  cancel the stage contents and the payload being accepted.
- mem_rf_zip  out  2+RA_W+DW  {rf_we&mem_valid, rf_waddr, rf_wdata, mem_loading}.

## Operation
- State: mem_valid, payload register, resp_got (response received for the current instruction), discard_cnt.
- mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
- Payload capture: on ex_to_mem_valid & mem_allowin & ~mem_flush, load the payload and clear resp_got.
- mem_valid update when mem_allowin: mem_valid <= ex_to_mem_valid & ~mem_flush.
- Flush: mem_flush forces mem_valid <= 0 whatever mem_allowin is.
- A response is "own" when data_ok & discard_cnt==0. A response with discard_cnt>0 is dropped and decrements the counter.
- mem_ready_go = ~req_issued | resp_got | own response this cycle.
- Discard counter on flush, evaluated in the same cycle:
  - +1 if mem_valid & req_issued & ~resp_got & ~(own data_ok this cycle);
  - +1 if ex_to_mem_valid & ex req_issued;
  - −1 if a data_ok arrives and is dropped;
  - saturates at MAX_OUT, which is a protocol error caught by an assertion.
- Load extraction uses alu_result low bits as the byte offset. Example for DW=32: H at offset 2 selects rdata[31:16].
  - Signed ops sign-extend to DW; U ops zero-extend.
  - Misaligned offsets are not checked here; EX guarantees alignment.
- rf_wdata = res_from_mem ? extracted load data : alu_result.
- mem_loading = mem_valid & res_from_mem & ~mem_ready_go. ID stalls on a matching address while this is set.

## Timing
- Reset, asynchronous: mem_valid=0, resp_got=0, buffer valid=0, discard_cnt=0, payload=0.
- Outputs during reset: mem_to_wb_valid=0, mem_rf_zip=0, mem_allowin=1.
- Non-memory instruction: one cycle in the stage; mem_to_wb_valid in the cycle after capture.
- Memory instruction: mem_to_wb_valid in the cycle data_ok arrives at the earliest, so zero added latency from the response.
- Stall: if wb_allowin=0 when the stage is ready, all outputs hold stable until transfer.
- Flush and data_ok in the same cycle with discard_cnt==0: the response counts as own and is not discarded, and the instruction is dropped. The counter does not increment for it.
- Reset mid-request: the counter returns to 0. The bus is reset by the same resetn.

## Configuration
- MEM_RESP_BUF_EN defined:
  - A DW-bit response buffer captures rdata on an own data_ok while wb_allowin=0.
  - resp_got then holds mem_ready_go high, and extraction reads the buffer.
- MEM_RESP_BUF_EN undefined:
  - No buffer; the stage uses rdata only in the data_ok cycle.
  - WB must assert wb_allowin whenever it receives data. An assertion flags an own data_ok with wb_allowin=0.

## Test plan
- ALU op, rf_we=1, waddr=3, alu_result=0x1234: mem_to_wb_wire wdata=0x1234 one cycle later; zip = {1,3,0x1234,0}.
- LB at offset 3, rdata=0x80FF_FF00, data_ok 2 cycles after capture:
  - mem_loading=1 for 2 cycles;
  - wdata=0xFFFF_FF80 in the data_ok cycle.
- LHU at offset 2, rdata=0x9ABC_0000: wdata=0x0000_9ABC.
- Flush with one pending load in MEM plus an issued request in EX:
  - discard_cnt=2;
  - the next two data_ok are dropped;
  - the third data_ok completes the new load.
- With MEM_RESP_BUF_EN: data_ok with rdata=0xDEAD_BEEF while wb_allowin=0 for 3 cycles. LW delivers 0xDEAD_BEEF on the first cycle wb_allowin=1.
- Assert resetn=0 asynchronously mid-wait: mem_to_wb_valid=0 and discard_cnt=0 immediately, before the next clock edge.
